// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared target codes and deframer states for the MCU SPI target.
package mcu_spi_pkg;
    localparam int NUM_TGT = 4;
    typedef enum logic [1:0] {
        TGT_SYS = 2'd0,
        TGT_HID = 2'd1,
        TGT_OSD = 2'd2,
        TGT_SDC = 2'd3
    } tgt_t;
    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_TARGET,
        S_CMD,
        S_DATA,
        S_DISCARD
    } state_t;
endpackage

// File: rtl/mcu_spi_target_if.sv
// mcu_spi_target_if: SPI pins plus the byte bus shared by the downstream control targets.
interface mcu_spi_target_if;
    logic        spi_ss;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [3:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_data;
    logic [31:0] tgt_reply;
    modport slave (
        input  spi_ss, spi_sclk, spi_mosi, tgt_reply,
        output spi_miso, tgt_strobe, tgt_start, tgt_data
    );
    modport master (
        output spi_ss, spi_sclk, spi_mosi, tgt_reply,
        input  spi_miso, tgt_strobe, tgt_start, tgt_data
    );
endinterface

// File: rtl/mcu_spi_target_sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous pin with rise/fall detection.
module sync_edge #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    // r_sync[STAGES-1] is the synchronized level; r_sync[STAGES] is its previous sample.
    logic [STAGES:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else r_sync <= {r_sync[STAGES-1:0], i_d};
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_sync[STAGES];
    assign o_fall = ~r_sync[STAGES-1] & r_sync[STAGES];
endmodule

// File: rtl/mcu_spi_target.sv
// mcu_spi_target: oversampled mode-0 SPI target that deframes MCU transactions into
// per-target byte strobes and shifts the selected target's reply back on MISO.
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic              clk,
    input  logic              reset,
    mcu_spi_target_if.slave   bus,
    output logic              busy
);
    state_t               r_state, w_next;
    tgt_t                 r_sel;
    logic [2:0]           r_bit_cnt;
    logic [6:0]           r_rx_sr;
    logic [7:0]           r_tx_sr;
    logic [NUM_TGT-1:0]   r_strobe;
    logic                 r_start;
    logic [7:0]           r_data;
    logic                 r_ld;
    logic                 w_ss, w_ss_rise, w_ss_fall;
    logic                 w_sclk_rise, w_sclk_fall;
    logic                 w_mosi;
    logic                 w_unused_sclk_lvl;
    logic [1:0]           w_unused_mosi_edges;
    logic [7:0]           w_rx_byte;
    logic                 w_shift, w_byte_done, w_valid_tgt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .reset(reset), .i_d(bus.spi_ss),
        .o_q(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .i_d(bus.spi_sclk),
        .o_q(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .reset(reset), .i_d(bus.spi_mosi),
        .o_q(w_mosi), .o_rise(w_unused_mosi_edges[0]), .o_fall(w_unused_mosi_edges[1])
    );

    assign busy        = (r_state != S_WAIT_IDLE) && (r_state != S_IDLE);
    assign w_rx_byte   = {r_rx_sr, w_mosi};
    // A high synchronized SS already blocks byte completion, so SS rising wins over the last edge.
    assign w_shift     = w_sclk_rise & ~w_ss & busy;
    assign w_byte_done = w_shift & (r_bit_cnt == 3'd7);
    assign w_valid_tgt = w_rx_byte < 8'(NUM_TGT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_IDLE: w_next = w_ss ? S_IDLE : S_WAIT_IDLE;
            S_IDLE:      w_next = w_ss_fall ? S_TARGET : S_IDLE;
            S_TARGET:    w_next = w_byte_done ? (w_valid_tgt ? S_CMD : S_DISCARD) : S_TARGET;
            S_CMD:       w_next = w_byte_done ? S_DATA : S_CMD;
            default:     w_next = r_state;
        endcase
        if (busy && w_ss_rise) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= TGT_SYS;
            r_bit_cnt <= '0;
            r_rx_sr   <= '0;
            r_tx_sr   <= '0;
            r_strobe  <= '0;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_ld      <= 1'b0;
        end else begin
            r_strobe <= '0;
            r_start  <= 1'b0;
            r_ld     <= |r_strobe;
            if (r_state == S_IDLE && w_ss_fall) r_bit_cnt <= '0;
            if (w_shift) begin
                r_rx_sr   <= w_rx_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done && r_state == S_TARGET && w_valid_tgt) r_sel <= tgt_t'(w_rx_byte[1:0]);
            if (w_byte_done && (r_state == S_CMD || r_state == S_DATA)) begin
                r_strobe <= 4'b0001 << r_sel;
                r_start  <= r_state == S_CMD;
                r_data   <= w_rx_byte;
            end
            // The reply is sampled one cycle after the strobe so the target can update it first.
            if (r_state == S_IDLE) r_tx_sr <= '0;
            else if (r_ld && r_state == S_DATA) r_tx_sr <= bus.tgt_reply[{r_sel, 3'b000} +: 8];
            else if (w_sclk_fall && !w_ss && r_bit_cnt != 3'd0 && (r_state == S_CMD || r_state == S_DATA))
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
        end
    end

    assign bus.spi_miso   = r_tx_sr[7] & ~w_ss;
    assign bus.tgt_strobe = r_strobe;
    assign bus.tgt_start  = r_start;
    assign bus.tgt_data   = r_data;
endmodule

// File: tb/tb_mcu_spi_target.sv
// tb_mcu_spi_target: drives SPI frames as an MCU, plays the four targets, and checks
// strobes and MISO against a frame-level model of the deframing rules.
module tb_mcu_spi_target;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          half = 8;
    int          busy_low = 0;
    logic [7:0]  last_data = 8'h00;
    logic [12:0] obs[$];
    logic [7:0]  plan[$];

    mcu_spi_target_if tb_if();

    mcu_spi_target #(.SYNC_STAGES(3)) dut (
        .clk(clk), .reset(reset), .bus(tb_if), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target model: record each strobe and post the next planned reply byte.
    always @(negedge clk) begin
        logic [7:0] nv;
        if (reset) tb_if.tgt_reply = '0;
        else if (tb_if.tgt_strobe != 4'b0000) begin
            obs.push_back({tb_if.tgt_strobe, tb_if.tgt_start, tb_if.tgt_data});
            if (plan.size() > 0) begin
                nv = plan.pop_front();
                for (int n = 0; n < 4; n++)
                    if (tb_if.tgt_strobe[n]) tb_if.tgt_reply[8*n +: 8] = nv;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            tb_if.spi_mosi = b[i];
            repeat (half) @(negedge clk);
            rx[i] = tb_if.spi_miso;
            if (!busy) busy_low++;
            tb_if.spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            tb_if.spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fb[$], input logic [7:0] rp[$]);
        logic [7:0] rx;
        logic [7:0] mq[$];
        logic       acc;
        logic [3:0] oh;
        obs.delete();
        plan = rp;
        busy_low = 0;
        tb_if.spi_ss = 1'b0;
        repeat (half) @(negedge clk);
        foreach (fb[k]) begin
            spi_bits(fb[k], 8, rx);
            mq.push_back(rx);
        end
        repeat (half) @(negedge clk);
        tb_if.spi_ss = 1'b1;
        repeat (2 * half + 8) @(negedge clk);
        acc = fb[0] < 8'd4;
        oh = 4'b0001 << fb[0][1:0];
        chk({tag, " strobe count"}, obs.size(), acc ? fb.size() - 1 : 0);
        for (int k = 1; k < fb.size(); k++)
            if (acc && k - 1 < obs.size())
                chk($sformatf("%s byte%0d strobe/start/data", tag, k), 32'(obs[k-1]), 32'({oh, k == 1, fb[k]}));
        for (int k = 0; k < mq.size(); k++)
            chk($sformatf("%s miso byte%0d", tag, k), 32'(mq[k]), 32'((acc && k >= 2) ? rp[k-2] : 8'h00));
        chk({tag, " busy during frame"}, busy_low, 0);
        chk({tag, " busy after frame"}, busy, 0);
        if (acc && fb.size() > 1) last_data = fb[fb.size()-1];
        chk({tag, " tgt_data hold"}, tb_if.tgt_data, last_data);
    endtask

    initial begin
        logic [7:0] fb[$];
        logic [7:0] rp[$];
        logic [7:0] rx;
        int         n;
        tb_if.spi_ss = 1'b0;
        tb_if.spi_sclk = 1'b0;
        tb_if.spi_mosi = 1'b0;
        // Step 1: reset with SS held low; the rest of that frame must be ignored.
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset miso", tb_if.spi_miso, 0);
        chk("reset strobe", tb_if.tgt_strobe, 0);
        chk("reset start", tb_if.tgt_start, 0);
        chk("reset data", tb_if.tgt_data, 0);
        chk("reset busy", busy, 0);
        obs.delete();
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h01, 8, rx);
        repeat (half) @(negedge clk);
        chk("t1 no strobes", obs.size(), 0);
        chk("t1 busy", busy, 0);
        chk("t1 miso", tb_if.spi_miso, 0);
        tb_if.spi_ss = 1'b1;
        repeat (12) @(negedge clk);
        // Step 2: target 0 with reply sequence.
        fb = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        rp = '{8'h5C, 8'h42, 8'h00};
        run_frame("t2", fb, rp);
        // Step 3: target 2.
        fb = '{8'h02, 8'h07, 8'hA5};
        rp = '{8'h33};
        run_frame("t3", fb, rp);
        // Step 4: invalid target byte is discarded.
        fb = '{8'h09, 8'h11, 8'h22};
        rp.delete();
        run_frame("t4", fb, rp);
        // Step 5: abort mid-byte, then a clean frame.
        obs.delete();
        plan.delete();
        tb_if.spi_ss = 1'b0;
        repeat (half) @(negedge clk);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h55, 5, rx);
        repeat (half) @(negedge clk);
        tb_if.spi_ss = 1'b1;
        repeat (2 * half + 8) @(negedge clk);
        chk("t5 aborted strobes", obs.size(), 0);
        chk("t5 aborted data hold", tb_if.tgt_data, last_data);
        chk("t5 aborted busy", busy, 0);
        fb = '{8'h00, 8'h03};
        rp.delete();
        run_frame("t5", fb, rp);
        // Step 6: minimum SCLK half-period, long frame to target 3.
        half = 6;
        fb = '{8'h03};
        rp.delete();
        for (int i = 1; i < 64; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < 64; i++) rp.push_back(8'($urandom));
        run_frame("t6", fb, rp);
        // Randomized frames, including invalid targets and varied SCLK rates.
        for (int f = 0; f < 4; f++) begin
            half = $urandom_range(6, 10);
            n = $urandom_range(2, 9);
            fb.delete();
            rp.delete();
            fb.push_back(8'($urandom_range(0, 5)));
            for (int i = 1; i < n; i++) fb.push_back(8'($urandom));
            for (int i = 0; i < n; i++) rp.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", f), fb, rp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
